if_stage: RTL and testbench

- Instruction-fetch stage. Sits directly upstream of `inst_memory` and owns the program counter.
- Drives `pc_out` into `inst_memory` and takes its combinational `instr_word` back.
- Registers the fetched word, its PC and PC+4 into the IF/ID pipeline register for decode.
- Handles decode stalls, taken-branch/jump redirects from execute, and misaligned-target faults.

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads inst_memory combinationally and
// registers the fetched word, its PC and PC+4 into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_word,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    FAULT   = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] plus4_q, plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  // Handshake: IF/ID offers (if_id_valid) and decode accepts unless stall is
  // high; a stalled register and PC hold until stall drops. Redirects win.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    plus4_d = plus4_q;
    instr_d = instr_q;
    fault_d = fault_q;
    count_d = count_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (!stall) begin
          ifpc_d  = pc_q;
          plus4_d = pc_inc;
          instr_d = instr_word;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          count_d = count_q + 32'd1;
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ifpc_q  <= 32'd0;
      plus4_q <= 32'd0;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ifpc_q  <= ifpc_d;
      plus4_q <= plus4_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = plus4_q;
  assign if_id_instr    = instr_q;
  assign fetch_fault    = fault_q;
  assign fetch_count    = count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written fault/reset/wrap
// sequences, then randomized traffic against a transaction-level model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out, instr_word;
  logic        stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_id_valid, fetch_fault;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
  logic [1:0]  state_dbg;

  logic [31:0] w_pc_out, w_instr_word;
  logic        w_stall = 1'b0, w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'd0;
  logic        w_if_id_valid, w_fetch_fault;
  logic [31:0] w_if_id_pc, w_if_id_pc_plus4, w_if_id_instr, w_fetch_count;
  logic [1:0]  w_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000_0000 + k
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction
  assign instr_word   = mem_word(pc_out);
  assign w_instr_word = 32'h2000_0000 ^ w_pc_out;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .instr_word(instr_word),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .fetch_fault(fetch_fault), .fetch_count(fetch_count),
    .state_dbg(state_dbg)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .pc_out(w_pc_out), .instr_word(w_instr_word),
    .stall(w_stall), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .if_id_valid(w_if_id_valid), .if_id_pc(w_if_id_pc), .if_id_pc_plus4(w_if_id_pc_plus4),
    .if_id_instr(w_if_id_instr), .fetch_fault(w_fetch_fault), .fetch_count(w_fetch_count),
    .state_dbg(w_state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pc_out"}, pc_out, 32'd0);
    check({tag, " valid"}, 32'(if_id_valid), 32'd0);
    check({tag, " if_pc"}, if_id_pc, 32'd0);
    check({tag, " plus4"}, if_id_pc_plus4, 32'd0);
    check({tag, " instr"}, if_id_instr, NOP);
    check({tag, " fault"}, 32'(fetch_fault), 32'd0);
    check({tag, " count"}, fetch_count, 32'd0);
    check({tag, " state"}, 32'(state_dbg), 32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        chk_ifpc;
    logic [31:0] e_ifpc;
    logic [31:0] e_plus4;
    logic [31:0] e_instr;
    logic        e_fault;
    logic [31:0] e_count;
    logic [1:0]  e_state;
  } vec_t;

  vec_t tbl[12];

  // Reference model state (architectural view of the fetch stage)
  logic [31:0] m_pc, m_ifpc, m_instr, m_count;
  logic        m_valid, m_fault, m_booted;

  task automatic model_reset();
    m_pc = 32'd0; m_ifpc = 32'd0; m_instr = NOP; m_count = 32'd0;
    m_valid = 1'b0; m_fault = 1'b0; m_booted = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] rpc);
    if (!m_booted) m_booted = 1'b1;
    else if (m_fault) m_valid = 1'b0;
    else if (rv && rpc[1:0] != 2'b00) begin
      m_fault = 1'b1; m_valid = 1'b0; m_instr = NOP;
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_instr = NOP;
    end else if (!s) begin
      m_ifpc = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end
  endtask

  initial begin
    // Directed vectors: boot, fetch, stall, redirect, redirect+stall, misalign
    tbl[0]  = '{0, 0, 32'h0,  32'h0,  0, 1, 32'h0,  32'h0,  NOP,          0, 0, 2'd1};
    tbl[1]  = '{0, 0, 32'h0,  32'h4,  1, 1, 32'h0,  32'h4,  32'h1000_0000, 0, 1, 2'd1};
    tbl[2]  = '{0, 0, 32'h0,  32'h8,  1, 1, 32'h4,  32'h8,  32'h1000_0001, 0, 2, 2'd1};
    tbl[3]  = '{1, 0, 32'h0,  32'h8,  1, 1, 32'h4,  32'h8,  32'h1000_0001, 0, 2, 2'd1};
    tbl[4]  = '{1, 0, 32'h0,  32'h8,  1, 1, 32'h4,  32'h8,  32'h1000_0001, 0, 2, 2'd1};
    tbl[5]  = '{1, 0, 32'h0,  32'h8,  1, 1, 32'h4,  32'h8,  32'h1000_0001, 0, 2, 2'd1};
    tbl[6]  = '{0, 0, 32'h0,  32'hC,  1, 1, 32'h8,  32'hC,  32'h1000_0002, 0, 3, 2'd1};
    tbl[7]  = '{0, 1, 32'h40, 32'h40, 0, 0, 32'h0,  32'h0,  NOP,          0, 3, 2'd1};
    tbl[8]  = '{0, 0, 32'h0,  32'h44, 1, 1, 32'h40, 32'h44, 32'h1000_0010, 0, 4, 2'd1};
    tbl[9]  = '{1, 1, 32'h80, 32'h80, 0, 0, 32'h0,  32'h0,  NOP,          0, 4, 2'd1};
    tbl[10] = '{0, 0, 32'h0,  32'h84, 1, 1, 32'h80, 32'h84, 32'h1000_0020, 0, 5, 2'd1};
    tbl[11] = '{0, 1, 32'h42, 32'h84, 0, 0, 32'h0,  32'h0,  NOP,          1, 5, 2'd2};

    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stall;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      step();
      check($sformatf("v%0d pc_out", i), pc_out, tbl[i].e_pc);
      check($sformatf("v%0d valid", i), 32'(if_id_valid), 32'(tbl[i].e_valid));
      if (tbl[i].chk_ifpc) begin
        check($sformatf("v%0d if_pc", i), if_id_pc, tbl[i].e_ifpc);
        check($sformatf("v%0d plus4", i), if_id_pc_plus4, tbl[i].e_plus4);
      end
      check($sformatf("v%0d instr", i), if_id_instr, tbl[i].e_instr);
      check($sformatf("v%0d fault", i), 32'(fetch_fault), 32'(tbl[i].e_fault));
      check($sformatf("v%0d count", i), fetch_count, tbl[i].e_count);
      check($sformatf("v%0d state", i), 32'(state_dbg), 32'(tbl[i].e_state));
    end

    // FAULT is terminal: further redirects and stalls change nothing
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom_range(0, 1));
      redirect_valid = 1'b1;
      redirect_pc = $urandom & 32'h0000_0FFC;
      step();
      check("frozen pc_out", pc_out, 32'h84);
      check("frozen valid", 32'(if_id_valid), 32'd0);
      check("frozen fault", 32'(fetch_fault), 32'd1);
      check("frozen count", fetch_count, 32'd5);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;

    // Asynchronous reset in mid-cycle, sampled before any clock edge
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    step();
    rst = 1'b0;

    // Wrap instance: RESET_PC = FFFF_FFF8, already out of reset above
    check("wrap boot pc_out", w_pc_out, 32'hFFFF_FFF8);
    check("wrap boot valid", 32'(w_if_id_valid), 32'd0);
    step();
    check("wrap b pc_out", w_pc_out, 32'hFFFF_FFF8);
    check("wrap b valid", 32'(w_if_id_valid), 32'd0);
    step();
    check("wrap f0 if_pc", w_if_id_pc, 32'hFFFF_FFF8);
    check("wrap f0 plus4", w_if_id_pc_plus4, 32'hFFFF_FFFC);
    check("wrap f0 instr", w_if_id_instr, 32'h2000_0000 ^ 32'hFFFF_FFF8);
    step();
    check("wrap f1 if_pc", w_if_id_pc, 32'hFFFF_FFFC);
    check("wrap f1 plus4", w_if_id_pc_plus4, 32'h0000_0000);
    check("wrap f1 pc_out", w_pc_out, 32'h0000_0000);
    step();
    check("wrap f2 if_pc", w_if_id_pc, 32'h0000_0000);
    check("wrap f2 plus4", w_if_id_pc_plus4, 32'h0000_0004);
    check("wrap f2 fault", 32'(w_fetch_fault), 32'd0);
    check("wrap f2 count", w_fetch_count, 32'd3);

    // Randomized traffic against the model
    rst = 1'b1;
    #1;
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic s, rv;
      logic [31:0] rpc;
      if ($urandom_range(0, 79) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rand rst pc_out", pc_out, m_pc);
        check("rand rst count", fetch_count, m_count);
        step();
        rst = 1'b0;
      end
      s = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      stall = s;
      redirect_valid = rv;
      redirect_pc = rpc;
      model_edge(s, rv, rpc);
      step();
      check("rand pc_out", pc_out, m_pc);
      check("rand valid", 32'(if_id_valid), 32'(m_valid));
      check("rand fault", 32'(fetch_fault), 32'(m_fault));
      check("rand count", fetch_count, m_count);
      check("rand instr", if_id_instr, m_instr);
      if (m_valid) begin
        check("rand if_pc", if_id_pc, m_ifpc);
        check("rand plus4", if_id_pc_plus4, m_ifpc + 32'd4);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
